motoro3_commutator: RTL and testbench

//  Parametrised 3-phase commutation sequencer; successor to the fixed 6-step counter.

---
 rtl/motoro3_commutator.sv | 218 +++++++++++++++++++++
 tb/tb_motoro3_commutator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : motoro3_commutator
//  Description : Parametrised 3-phase commutation sequencer. Steps through
//                STEPS commutation states, forward or reverse, at a period
//                of (reload+1) clocks where reload = freq << CNT_SHIFT.
//                Supports restart on a start rising edge, a timed brake
//                state followed by idle, and a one-cycle step strobe.
//                Optional soft start is compiled in with MOTORO3_RAMP_EN.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous reset, active high
//                start    - level; rising edge starts/restarts the sequence
//                stop     - level; high requests brake
//                dir      - 0 forward (1..STEPS), 1 reverse (STEPS..1)
//                freq     - period control, sampled at each reload
//                step     - 0 idle, 1..STEPS run, STEPS+1 brake
//                cnt      - period down-counter
//                step_stb - one-cycle pulse on every step load/advance
//                busy     - high whenever step != 0
//  Revision    : 1.0  initial release
// ============================================================================
module motoro3_commutator #(
    parameter int FREQ_W    = 10,
    parameter int CNT_SHIFT = 6,
    parameter int STEPS     = 6,
    parameter int BRAKE_CYC = 16,
    parameter int CNT_W     = FREQ_W + CNT_SHIFT + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic [FREQ_W-1:0] freq,
    output logic [3:0]        step,
    output logic [CNT_W-1:0]  cnt,
    output logic              step_stb,
    output logic              busy
);

    localparam int         BC_W         = (BRAKE_CYC > 1) ? $clog2(BRAKE_CYC) : 1;
    localparam logic [3:0] c_STEP_IDLE  = 4'd0;
    localparam logic [3:0] c_STEP_FIRST = 4'd1;
    localparam logic [3:0] c_STEP_LAST  = 4'(STEPS);
    localparam logic [3:0] c_STEP_BRAKE = 4'(STEPS + 1);
    localparam logic [BC_W-1:0] c_BRAKE_LOAD = BC_W'(BRAKE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_BRAKE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_step,  w_step_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_stb,   w_stb_nxt;
    logic [BC_W-1:0]   r_bcnt,  w_bcnt_nxt;
    logic              r_start_q;

    logic              w_start_up;
    logic              w_freq_zero;
    logic              w_wrap;
    logic [3:0]        w_step_adv;
    logic [CNT_W-1:0]  w_freq_ext;
    logic [CNT_W-1:0]  w_reload_start;
    logic [CNT_W-1:0]  w_reload_adv;

    assign w_start_up  = start & ~r_start_q;
    assign w_freq_zero = (freq == '0);
    assign w_freq_ext  = CNT_W'(freq);

    // Wrap is "completing an electrical turn": past the last step in the
    // current direction. dir is sampled here, at the advance itself.
    always_comb begin
        w_wrap     = 1'b0;
        w_step_adv = r_step;
        if (dir == 1'b0) begin
            if (r_step == c_STEP_LAST) begin
                w_wrap     = 1'b1;
                w_step_adv = c_STEP_FIRST;
            end else begin
                w_step_adv = r_step + 4'd1;
            end
        end else begin
            if (r_step == c_STEP_FIRST) begin
                w_wrap     = 1'b1;
                w_step_adv = c_STEP_LAST;
            end else begin
                w_step_adv = r_step - 4'd1;
            end
        end
    end

`ifdef MOTORO3_RAMP_EN
    // Soft start: extra shift starts at 3 on every (re)start and drops by one
    // per completed turn, so the first turn runs 8x slower, then 4x, 2x, 1x.
    logic [1:0] r_rs, w_rs_nxt, w_rs_adv;

    assign w_rs_adv       = (w_wrap && (r_rs != 2'd0)) ? (r_rs - 2'd1) : r_rs;
    assign w_reload_start = w_freq_ext << (CNT_SHIFT + 3);
    assign w_reload_adv   = w_freq_ext << (CNT_SHIFT + int'(w_rs_adv));
`else
    assign w_reload_start = w_freq_ext << CNT_SHIFT;
    assign w_reload_adv   = w_freq_ext << CNT_SHIFT;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_stb_nxt   = 1'b0;
        w_bcnt_nxt  = r_bcnt;
`ifdef MOTORO3_RAMP_EN
        w_rs_nxt    = r_rs;
`endif
        case (r_state)
            S_IDLE: begin
                // stop only matters here when it arrives with a start edge
                if (w_start_up) begin
                    if (stop) begin
                        w_state_nxt = S_BRAKE;
                        w_step_nxt  = c_STEP_BRAKE;
                        w_cnt_nxt   = '0;
                        w_bcnt_nxt  = c_BRAKE_LOAD;
                        w_stb_nxt   = 1'b1;
                    end else if (!w_freq_zero) begin
                        w_state_nxt = S_RUN;
                        w_step_nxt  = dir ? c_STEP_LAST : c_STEP_FIRST;
                        w_cnt_nxt   = w_reload_start;
                        w_stb_nxt   = 1'b1;
`ifdef MOTORO3_RAMP_EN
                        w_rs_nxt    = 2'd3;
`endif
                    end
                end
            end
            S_RUN: begin
                // A zero freq at any reload point is treated as a stop.
                if (stop || (w_start_up && w_freq_zero) ||
                    (!w_start_up && (r_cnt == '0) && w_freq_zero)) begin
                    w_state_nxt = S_BRAKE;
                    w_step_nxt  = c_STEP_BRAKE;
                    w_cnt_nxt   = '0;
                    w_bcnt_nxt  = c_BRAKE_LOAD;
                    w_stb_nxt   = 1'b1;
                end else if (w_start_up) begin
                    w_step_nxt  = dir ? c_STEP_LAST : c_STEP_FIRST;
                    w_cnt_nxt   = w_reload_start;
                    w_stb_nxt   = 1'b1;
`ifdef MOTORO3_RAMP_EN
                    w_rs_nxt    = 2'd3;
`endif
                end else if (r_cnt == '0) begin
                    w_step_nxt  = w_step_adv;
                    w_cnt_nxt   = w_reload_adv;
                    w_stb_nxt   = 1'b1;
`ifdef MOTORO3_RAMP_EN
                    w_rs_nxt    = w_rs_adv;
`endif
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_BRAKE: begin
                // start edges are deliberately ignored until idle
                if (r_bcnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = c_STEP_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_bcnt_nxt  = r_bcnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = c_STEP_IDLE;
                w_cnt_nxt   = '0;
                w_bcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_step    <= c_STEP_IDLE;
            r_cnt     <= '0;
            r_stb     <= 1'b0;
            r_bcnt    <= '0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_cnt     <= w_cnt_nxt;
            r_stb     <= w_stb_nxt;
            r_bcnt    <= w_bcnt_nxt;
            r_start_q <= start;
        end
    end

`ifdef MOTORO3_RAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs <= 2'd0;
        end else begin
            r_rs <= w_rs_nxt;
        end
    end
`endif

    assign step     = r_step;
    assign cnt      = r_cnt;
    assign step_stb = r_stb;
    assign busy     = (r_step != c_STEP_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_motoro3_commutator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motoro3_commutator
//  Description : Directed self-checking bench for motoro3_commutator with
//                freq=1 (reload 64 << ramp shift). Inputs change and outputs
//                are sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_motoro3_commutator;

    localparam int FREQ_W = 10;
    localparam int CNT_W  = 19;
`ifdef MOTORO3_RAMP_EN
    localparam int RAMP0  = 3;
`else
    localparam int RAMP0  = 0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              dir;
    logic [FREQ_W-1:0] freq;
    logic [3:0]        step;
    logic [CNT_W-1:0]  cnt;
    logic              step_stb;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;
    int rs_m;
    int reload_m;

    motoro3_commutator u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .freq     (freq),
        .step     (step),
        .cnt      (cnt),
        .step_stb (step_stb),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // model a (re)start load at freq=1
    task automatic restart_model();
        rs_m     = RAMP0;
        reload_m = 64 << rs_m;
    endtask

    task automatic chk_load(input string tag, input int exp_step);
        chk({tag, "_step"}, 32'(step), 32'(exp_step));
        chk({tag, "_stb"},  32'(step_stb), 32'd1);
        chk({tag, "_cnt"},  32'(cnt), 32'(reload_m));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // wait out one full period from a load and check the next advance
    task automatic adv(input string tag, input int exp_step, input bit wrap);
        @(negedge clk);
        chk({tag, "_stb_lo"}, 32'(step_stb), 32'd0);
        repeat (reload_m - 1) @(negedge clk);
        chk({tag, "_cnt0"}, 32'(cnt), 32'd0);
        if (wrap && rs_m > 0) rs_m--;
        reload_m = 64 << rs_m;
        @(negedge clk);
        chk_load(tag, exp_step);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; freq = 10'd1;
        rs_m = 0; reload_m = 64;

        // reset
        repeat (2) @(negedge clk);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_cnt",  32'(cnt),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stb",  32'(step_stb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_step", 32'(step), 32'd0);

        // forward run
        start = 1'b1;
        restart_model();
        @(negedge clk);
        chk_load("fwd_load", 1);
        adv("fwd2", 2, 1'b0);
        adv("fwd3", 3, 1'b0);
        adv("fwd4", 4, 1'b0);
        adv("fwd5", 5, 1'b0);
        adv("fwd6", 6, 1'b0);
        adv("fwd_wrap", 1, 1'b1);
        adv("fwd2b", 2, 1'b0);

        // reverse restart from RUN, then flip direction mid-run
        start = 1'b0;
        @(negedge clk);
        dir = 1'b1; start = 1'b1;
        restart_model();
        @(negedge clk);
        chk_load("rev_load", 6);
        adv("rev5", 5, 1'b0);
        adv("rev4", 4, 1'b0);
        adv("rev3", 3, 1'b0);
        adv("rev2", 2, 1'b0);
        adv("rev1", 1, 1'b0);
        adv("rev_wrap", 6, 1'b1);
        dir = 1'b0;
        adv("flip1", 1, 1'b1);
        adv("flip2", 2, 1'b0);
        adv("flip3", 3, 1'b0);

        // stop at step 3
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        chk("brk_step", 32'(step), 32'd7);
        chk("brk_stb",  32'(step_stb), 32'd1);
        chk("brk_busy", 32'(busy), 32'd1);
        stop = 1'b0;
        repeat (15) @(negedge clk);
        chk("brk_hold", 32'(step), 32'd7);
        chk("brk_hold_stb", 32'(step_stb), 32'd0);
        @(negedge clk);
        chk("brk_idle", 32'(step), 32'd0);
        chk("brk_idle_busy", 32'(busy), 32'd0);
        chk("brk_idle_cnt", 32'(cnt), 32'd0);

        // stop + start same cycle from IDLE, start edge ignored in BRAKE
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        chk("ss_brk", 32'(step), 32'd7);
        chk("ss_brk_stb", 32'(step_stb), 32'd1);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("brk_ign_start", 32'(step), 32'd7);
        repeat (13) @(negedge clk);
        chk("ss_hold", 32'(step), 32'd7);
        @(negedge clk);
        chk("ss_idle", 32'(step), 32'd0);

        // stop in IDLE has no effect
        stop = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_stop", 32'(step), 32'd0);
        chk("idle_stop_stb", 32'(step_stb), 32'd0);
        stop = 1'b0;

        // freq==0 at reload -> brake
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        restart_model();
        @(negedge clk);
        chk_load("fz_load", 1);
        freq = 10'd0;
        repeat (reload_m) @(negedge clk);
        chk("fz_cnt0", 32'(cnt), 32'd0);
        chk("fz_pre", 32'(step), 32'd1);
        @(negedge clk);
        chk("fz_brk", 32'(step), 32'd7);
        chk("fz_brk_stb", 32'(step_stb), 32'd1);
        repeat (16) @(negedge clk);
        chk("fz_idle", 32'(step), 32'd0);

        // start edge with freq==0 in IDLE is ignored
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("fz_start_step", 32'(step), 32'd0);
        chk("fz_start_stb",  32'(step_stb), 32'd0);
        chk("fz_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("fz_start_stay", 32'(step), 32'd0);

        // reset mid-run
        freq = 10'd1; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        restart_model();
        @(negedge clk);
        chk_load("mr_load", 1);
        repeat (10) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("mr_step", 32'(step), 32'd0);
        chk("mr_cnt",  32'(cnt),  32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_stb",  32'(step_stb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
